music_box_state_play_recording: RTL and testbench
=================================================

Name: music_box_state_play_recording

Overview:
- Playback counterpart of the recording state: when the state controller selects PLAY_STATE, reads stored samples from recording memory in address order, one per 1 kHz tick.
- Presents each sample to the audio path with a one-cycle valid strobe.
- Holds stateComplete once the recorded length has been played, so the controller can return to DoNothing.

Parameters:
- PLAY_STATE, 5'd2, currentState encoding that activates this block.
- ADDR_WIDTH, 13, recording memory address width (covers 5000 samples).
- DATA_WIDTH, 8, sample width.
- RD_TIMEOUT, 16, max clock_50Mhz cycles from mem_rd_en to mem_rd_valid before the block aborts.

Ports:
- clock_50Mhz  in  1  sole clock.
- reset  in  1  asynchronous, active-high reset.
- tick_1Khz  in  1  one-cycle enable at 1 kHz, synchronous to clock_50Mhz.
- currentState  in  5  state from the state controller.
- rec_length  in  ADDR_WIDTH  number of valid samples stored; latched on entry.
- mem_rd_en  out  1  one-cycle read request.
- mem_addr  out  ADDR_WIDTH  read address, valid while mem_rd_en=1.
- mem_rd_valid  in  1  read data valid, 1..RD_TIMEOUT cycles after mem_rd_en.
- mem_rd_data  in  DATA_WIDTH  read data.
- sample_out  out  DATA_WIDTH  last sample played.
- sample_valid  out  1  one-cycle strobe when sample_out updates.
- stateComplete  out  1  playback finished (level).
- debugString  out  32  debug data.

Behaviour:
- Reset (async, active-high) clears all outputs: mem_rd_en=0, mem_addr=0, sample_out=0, sample_valid=0, stateComplete=0, debugString=0. FSM goes to IDLE, and the underrun count and error flag are cleared.
- FSM states: IDLE, ARM, FETCH, WAIT, DONE.
- IDLE: when currentState==PLAY_STATE, latch rec_length to len and set addr=0, then go to ARM.
- ARM: if len==0, go to DONE. Otherwise wait for tick_1Khz, then go to FETCH.
- FETCH: hold mem_rd_en=1 with mem_addr=addr for exactly one cycle, then go to WAIT.
- WAIT:
  - On mem_rd_valid, register sample_out<=mem_rd_data with sample_valid=1 for one cycle, the cycle after mem_rd_valid. Then set addr<=addr+1.
  - If the new addr == len, go to DONE; otherwise go to ARM.
  - Sample latency: tick to sample_valid = 2 + memory latency cycles.
- Underrun: a tick_1Khz arriving in FETCH or WAIT is dropped. The underrun count (8-bit, saturates at 255) increments.
- Timeout: if mem_rd_valid is absent for RD_TIMEOUT cycles in WAIT, set the error flag and go to DONE. Playback is not retried.
- DONE: stateComplete=1, held until currentState != PLAY_STATE. No further reads are issued.
- Leaving PLAY_STATE from any state:
  - Next cycle: FSM returns to IDLE, stateComplete=0, mem_rd_en=0.
  - A late mem_rd_valid is ignored.
  - sample_out keeps its value.
  - The underrun count and error flag clear on the next entry.
- Re-entry always restarts at addr 0.
- addr never exceeds len-1 on mem_addr, so there is no wrap-around.
- Simultaneous tick_1Khz and mem_rd_valid in WAIT: the sample is accepted and the tick counts as an underrun.
- debugString fields:
  - [31:24] underrun count
  - [23:21] FSM state (IDLE=0, ARM=1, FETCH=2, WAIT=3, DONE=4)
  - [20] error flag
  - [19:16] 0
  - [15:0] addr, zero-extended

Decomposition:
- Shared package music_box_pkg holds the currentState encodings (DO_NOTHING=0, MAKE_RECORDING=1, PLAY_RECORDING=2), the 5-bit state typedef, and the recording ADDR_WIDTH/DATA_WIDTH constants used by both the record and play blocks.
- The local FSM enum lives in this module.
- One sub-module is natural: tick_1khz_gen, a 50 MHz-to-1 kHz enable divider, instantiated at top level and shared with the recording state.

Test Plan:
- rec_length=3, memory returns 8'hA1/A2/A3 with 2-cycle latency, enter PLAY_STATE → three sample_valid pulses, one per tick, with the values in order. mem_addr sequence is 0,1,2. stateComplete rises after the third sample and stays 1 until the state changes.
- rec_length=0 → stateComplete=1 within 2 cycles of entry, mem_rd_en never asserted.
- Memory latency 20 cycles with RD_TIMEOUT=16 → debugString[20]=1, FSM enters DONE (debugString[23:21]=4), stateComplete=1, no sample_valid.
- Extra tick injected while in WAIT → debugString[31:24]=1 and the sample is still delivered. 300 injected ticks → count saturates at 255.
- currentState changed to 0 mid-playback (addr=2) → next cycle FSM=IDLE, stateComplete=0. Re-entry issues its first read at mem_addr=0.
- reset asserted mid-WAIT, asynchronously between clock edges → all outputs 0 immediately. A later mem_rd_valid produces no sample_valid.

Source files
------------

// File: rtl/music_box_pkg.sv
// Shared music box definitions: controller state encodings and recording memory geometry.
// Used by both the record and play state blocks.
package music_box_pkg;

    typedef enum logic [4:0] {
        DO_NOTHING     = 5'd0,
        MAKE_RECORDING = 5'd1,
        PLAY_RECORDING = 5'd2
    } music_state_t;

    localparam int REC_ADDR_WIDTH = 13;
    localparam int REC_DATA_WIDTH = 8;

endpackage

// File: rtl/music_box_state_play_recording.sv
// Plays recorded samples back in address order, one memory read per 1 kHz tick.
// Tick to sample_valid is 2 + memory latency cycles; ticks arriving mid-read are dropped and counted.
module music_box_state_play_recording
    import music_box_pkg::*;
#(
    parameter logic [4:0] PLAY_STATE = PLAY_RECORDING,
    parameter int         ADDR_WIDTH = REC_ADDR_WIDTH,
    parameter int         DATA_WIDTH = REC_DATA_WIDTH,
    parameter int         RD_TIMEOUT = 16
) (
    input  logic                  clock_50Mhz,
    input  logic                  reset,
    input  logic                  tick_1Khz,
    input  logic [4:0]            currentState,
    input  logic [ADDR_WIDTH-1:0] rec_length,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_rd_valid,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic [DATA_WIDTH-1:0] sample_out,
    output logic                  sample_valid,
    output logic                  stateComplete,
    output logic [31:0]           debugString
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARM   = 3'd1,
        FETCH = 3'd2,
        WAIT  = 3'd3,
        DONE  = 3'd4
    } play_state_t;

    localparam int TW = $clog2(RD_TIMEOUT + 1);

    play_state_t           state;
    play_state_t           state_nxt;
    logic [ADDR_WIDTH-1:0] len;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH-1:0] addr_inc;
    logic [TW-1:0]         tmo_cnt;
    logic [7:0]            underrun;
    logic                  err;
    logic                  active;
    logic                  accept;
    logic                  timeout;

    assign active   = (currentState == PLAY_STATE);
    assign addr_inc = addr + ADDR_WIDTH'(1);

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        timeout   = 1'b0;
        case (state)
            IDLE: begin
                if (active) state_nxt = ARM;
            end
            ARM: begin
                if (!active)           state_nxt = IDLE;
                else if (len == '0)    state_nxt = DONE;
                else if (tick_1Khz)    state_nxt = FETCH;
            end
            FETCH: begin
                state_nxt = active ? WAIT : IDLE;
            end
            WAIT: begin
                // Leaving the play state wins over a same-cycle read return.
                if (!active) begin
                    state_nxt = IDLE;
                end else if (mem_rd_valid) begin
                    accept    = 1'b1;
                    state_nxt = (addr_inc == len) ? DONE : ARM;
                end else if (tmo_cnt == TW'(RD_TIMEOUT - 1)) begin
                    timeout   = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (!active) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock_50Mhz or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            len          <= '0;
            addr         <= '0;
            tmo_cnt      <= '0;
            underrun     <= '0;
            err          <= 1'b0;
            sample_out   <= '0;
            sample_valid <= 1'b0;
        end else begin
            state        <= state_nxt;
            sample_valid <= accept;
            tmo_cnt      <= (state == WAIT) ? tmo_cnt + TW'(1) : '0;
            if (accept) begin
                sample_out <= mem_rd_data;
                addr       <= addr_inc;
            end
            if (state == IDLE && active) begin
                len      <= rec_length;
                addr     <= '0;
                underrun <= '0;
                err      <= 1'b0;
            end else begin
                if (tick_1Khz && (state == FETCH || state == WAIT) && underrun != 8'hFF)
                    underrun <= underrun + 8'd1;
                if (timeout)
                    err <= 1'b1;
            end
        end
    end

    assign mem_rd_en     = (state == FETCH);
    assign mem_addr      = mem_rd_en ? addr : '0;
    assign stateComplete = (state == DONE);
    assign debugString   = {underrun, 3'(state), err, 4'b0000, 16'(addr)};

endmodule

// File: tb/tb_music_box_state_play_recording.sv
// Directed bench for playback: memory responder with programmable latency feeds a sample scoreboard.
module tb_music_box_state_play_recording;

    logic        clk = 1'b0;
    logic        rst;
    logic        tick;
    logic [4:0]  cur_state;
    logic [12:0] rec_length;
    logic        mem_rd_en;
    logic [12:0] mem_addr;
    logic        mem_rd_valid;
    logic [7:0]  mem_rd_data;
    logic [7:0]  sample_out;
    logic        sample_valid;
    logic        state_complete;
    logic [31:0] debug_string;

    always #5 clk = ~clk;

    music_box_state_play_recording dut (
        .clock_50Mhz  (clk),
        .reset        (rst),
        .tick_1Khz    (tick),
        .currentState (cur_state),
        .rec_length   (rec_length),
        .mem_rd_en    (mem_rd_en),
        .mem_addr     (mem_addr),
        .mem_rd_valid (mem_rd_valid),
        .mem_rd_data  (mem_rd_data),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .stateComplete(state_complete),
        .debugString  (debug_string)
    );

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          lat = 2;
    bit          expect_samples = 1'b1;
    int          pend = 0;
    logic [12:0] paddr = '0;
    int          rd_cnt = 0;
    int          sample_cnt = 0;
    int          tick_cyc = 0;
    int          sample_cyc = 0;
    logic [7:0]  mem [0:8191];
    logic [7:0]  exp_q [$];
    logic [12:0] addr_log [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard pop, then memory model: answers each read after 'lat' cycles.
    always @(negedge clk) begin
        if (sample_valid === 1'b1) begin
            sample_cnt++;
            sample_cyc = cyc;
            if (exp_q.size() == 0) chk("unexpected_sample", {31'b0, sample_valid}, 32'd0);
            else                   chk("sample_data", {24'b0, sample_out}, {24'b0, exp_q.pop_front()});
        end
        mem_rd_valid = 1'b0;
        if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                mem_rd_valid = 1'b1;
                mem_rd_data  = mem[paddr];
            end
        end
        if (mem_rd_en === 1'b1) begin
            rd_cnt++;
            addr_log.push_back(mem_addr);
            paddr = mem_addr;
            pend  = lat;
            if (expect_samples && lat <= 16) exp_q.push_back(mem[mem_addr]);
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_tick();
        @(negedge clk);
        tick_cyc = cyc;
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic enter(input logic [12:0] len);
        @(negedge clk);
        rec_length = len;
        cur_state  = 5'd2;
    endtask

    task automatic leave();
        @(negedge clk);
        cur_state = 5'd0;
    endtask

    initial begin
        int rd0;
        int sc0;
        for (int i = 0; i < 8192; i++) mem[i] = 8'(i) ^ 8'h5A;
        mem[0] = 8'hA1; mem[1] = 8'hA2; mem[2] = 8'hA3;
        rst = 1'b1; tick = 1'b0; cur_state = 5'd0; rec_length = '0;
        mem_rd_valid = 1'b0; mem_rd_data = '0;

        // Reset state
        wait_cyc(2);
        chk("rst_rd_en",   {31'b0, mem_rd_en}, 0);
        chk("rst_addr",    {19'b0, mem_addr}, 0);
        chk("rst_sample",  {24'b0, sample_out}, 0);
        chk("rst_svalid",  {31'b0, sample_valid}, 0);
        chk("rst_complete",{31'b0, state_complete}, 0);
        chk("rst_debug",   debug_string, 0);
        @(negedge clk); rst = 1'b0;

        // Three-sample playback, latency 2
        lat = 2; expect_samples = 1'b1; addr_log.delete();
        enter(13'd3);
        wait_cyc(3);
        pulse_tick();
        wait_cyc(10);
        chk("latency_tick_to_sample", sample_cyc - tick_cyc, 4);
        pulse_tick();
        wait_cyc(10);
        chk("complete_before_last", {31'b0, state_complete}, 0);
        pulse_tick();
        wait_cyc(10);
        chk("play3_count", sample_cnt, 3);
        chk("play3_q_empty", exp_q.size(), 0);
        chk("play3_nreads", addr_log.size(), 3);
        for (int i = 0; i < 3 && i < addr_log.size(); i++)
            chk("play3_addr_seq", {19'b0, addr_log[i]}, i);
        chk("play3_complete", {31'b0, state_complete}, 1);
        chk("play3_fsm_done", {29'b0, debug_string[23:21]}, 4);
        chk("play3_dbg_addr", {16'b0, debug_string[15:0]}, 3);
        wait_cyc(5);
        chk("play3_complete_held", {31'b0, state_complete}, 1);
        leave();
        @(negedge clk);
        chk("play3_complete_drop", {31'b0, state_complete}, 0);
        chk("play3_sample_kept", {24'b0, sample_out}, 32'hA3);
        wait_cyc(2);

        // Zero-length recording
        rd0 = rd_cnt;
        enter(13'd0);
        wait_cyc(2);
        chk("zero_len_complete", {31'b0, state_complete}, 1);
        wait_cyc(5);
        chk("zero_len_no_read", rd_cnt - rd0, 0);
        leave();
        wait_cyc(2);

        // Read timeout: memory latency 20
        lat = 20; sc0 = sample_cnt; rd0 = rd_cnt;
        enter(13'd2);
        wait_cyc(3);
        pulse_tick();
        wait_cyc(30);
        chk("tmo_err_flag", {31'b0, debug_string[20]}, 1);
        chk("tmo_fsm_done", {29'b0, debug_string[23:21]}, 4);
        chk("tmo_complete", {31'b0, state_complete}, 1);
        chk("tmo_no_sample", sample_cnt - sc0, 0);
        chk("tmo_one_read", rd_cnt - rd0, 1);
        leave();
        wait_cyc(3);

        // Underrun: one extra tick during the read
        lat = 4; sc0 = sample_cnt;
        enter(13'd3);
        wait_cyc(3);
        chk("reentry_err_clear", {31'b0, debug_string[20]}, 0);
        pulse_tick();
        pulse_tick();
        wait_cyc(12);
        chk("underrun_one", {24'b0, debug_string[31:24]}, 1);
        chk("underrun_sample_kept", sample_cnt - sc0, 1);
        leave();
        wait_cyc(2);

        // Underrun saturation with ticks held for 300 cycles, max memory latency
        lat = 16;
        enter(13'd1000);
        wait_cyc(3);
        chk("underrun_cleared", {24'b0, debug_string[31:24]}, 0);
        @(negedge clk); tick = 1'b1;
        wait_cyc(300);
        tick = 1'b0;
        wait_cyc(25);
        chk("underrun_saturate", {24'b0, debug_string[31:24]}, 255);
        chk("lat16_no_timeout", {31'b0, debug_string[20]}, 0);
        chk("sat_q_empty", exp_q.size(), 0);
        leave();
        wait_cyc(3);

        // Leave mid-playback at addr 2, then re-enter
        lat = 2;
        enter(13'd5);
        wait_cyc(3);
        pulse_tick(); wait_cyc(8);
        pulse_tick(); wait_cyc(8);
        chk("mid_addr2", {16'b0, debug_string[15:0]}, 2);
        expect_samples = 1'b0;
        pulse_tick();
        cur_state = 5'd0;
        @(negedge clk);
        chk("mid_leave_idle", {29'b0, debug_string[23:21]}, 0);
        chk("mid_leave_complete", {31'b0, state_complete}, 0);
        chk("mid_leave_rd_en", {31'b0, mem_rd_en}, 0);
        chk("mid_leave_sample_kept", {24'b0, sample_out}, 32'hA2);
        wait_cyc(10);
        expect_samples = 1'b1; addr_log.delete();
        enter(13'd5);
        wait_cyc(3);
        pulse_tick();
        wait_cyc(8);
        chk("reentry_nreads", addr_log.size(), 1);
        if (addr_log.size() > 0) chk("reentry_addr0", {19'b0, addr_log[0]}, 0);
        chk("reentry_q_empty", exp_q.size(), 0);
        leave();
        wait_cyc(3);

        // Asynchronous reset in WAIT
        lat = 10; expect_samples = 1'b0; sc0 = sample_cnt;
        enter(13'd2);
        wait_cyc(3);
        pulse_tick();
        wait_cyc(2);
        chk("pre_rst_in_wait", {29'b0, debug_string[23:21]}, 3);
        #2 rst = 1'b1;
        #1;
        chk("arst_rd_en",   {31'b0, mem_rd_en}, 0);
        chk("arst_addr",    {19'b0, mem_addr}, 0);
        chk("arst_sample",  {24'b0, sample_out}, 0);
        chk("arst_svalid",  {31'b0, sample_valid}, 0);
        chk("arst_complete",{31'b0, state_complete}, 0);
        chk("arst_debug",   debug_string, 0);
        @(negedge clk);
        cur_state = 5'd0;
        rst = 1'b0;
        wait_cyc(15);
        chk("arst_late_valid_ignored", sample_cnt - sc0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
